// File: rtl/holy_clint_pkg.sv
// ============================================================================
// Module      : holy_clint_pkg
// Description : Shared offsets, response codes, state types and helpers for
//               the Holy Core CLINT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package holy_clint_pkg;

  localparam logic [31:0] CLINT_MSIP_OFF        = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP_LO_OFF = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIMECMP_HI_OFF = 32'h0000_4004;
  localparam logic [31:0] CLINT_MTIME_LO_OFF    = 32'h0000_BFF8;
  localparam logic [31:0] CLINT_MTIME_HI_OFF    = 32'h0000_BFFC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  typedef enum logic [2:0] {
    SEL_MSIP        = 3'd0,
    SEL_MTIMECMP_LO = 3'd1,
    SEL_MTIMECMP_HI = 3'd2,
    SEL_MTIME_LO    = 3'd3,
    SEL_MTIME_HI    = 3'd4,
    SEL_NONE        = 3'd5
  } reg_sel_e;

  // Offset must already be masked to the decoded width with bits [1:0] cleared.
  function automatic reg_sel_e decode_offset(input logic [31:0] off);
    reg_sel_e sel;
    case (off)
      CLINT_MSIP_OFF:        sel = SEL_MSIP;
      CLINT_MTIMECMP_LO_OFF: sel = SEL_MTIMECMP_LO;
      CLINT_MTIMECMP_HI_OFF: sel = SEL_MTIMECMP_HI;
      CLINT_MTIME_LO_OFF:    sel = SEL_MTIME_LO;
      CLINT_MTIME_HI_OFF:    sel = SEL_MTIME_HI;
      default:               sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/holy_clint_timer.sv
// ============================================================================
// Module      : holy_clint_timer
// Description : Prescaled 64-bit mtime with strobed bus-write override and
//               registered mtime >= mtimecmp comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module holy_clint_timer
  import holy_clint_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic [63:0] mtimecmp,
  output logic [63:0] mtime,
  output logic        timer_irq
);

  localparam logic [15:0] c_pre_last = 16'(PRESCALE - 1);

  logic [15:0] r_pre;
  logic        w_tick;
  logic [63:0] r_mtime;
  logic [63:0] w_mtime_next;
  logic        r_irq;

  assign w_tick = (r_pre == c_pre_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= 16'd0;
    end else begin
      r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
    end
  end

  // A bus write swallows the tick; the untouched half keeps its old value.
  always_comb begin
    w_mtime_next = r_mtime;
    if (wr_lo || wr_hi) begin
      if (wr_lo) w_mtime_next[31:0]  = merge_strb(r_mtime[31:0], wr_data, wr_strb);
      if (wr_hi) w_mtime_next[63:32] = merge_strb(r_mtime[63:32], wr_data, wr_strb);
    end else if (w_tick) begin
      w_mtime_next = r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime <= 64'd0;
      r_irq   <= 1'b0;
    end else begin
      r_mtime <= w_mtime_next;
      r_irq   <= (r_mtime >= mtimecmp);
    end
  end

  assign mtime     = r_mtime;
  assign timer_irq = r_irq;

endmodule

`default_nettype wire

// File: rtl/holy_clint.sv
// ============================================================================
// Module      : holy_clint
// Description : AXI-Lite core-local interruptor (msip, mtime, mtimecmp).
//               Define HOLY_CLINT_MTIME_LATCH_EN for coherent 64-bit mtime reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module holy_clint
  import holy_clint_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int PRESCALE   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axi_lite_awaddr,
  input  logic        s_axi_lite_awvalid,
  output logic        s_axi_lite_awready,
  input  logic [31:0] s_axi_lite_wdata,
  input  logic [3:0]  s_axi_lite_wstrb,
  input  logic        s_axi_lite_wvalid,
  output logic        s_axi_lite_wready,
  output logic [1:0]  s_axi_lite_bresp,
  output logic        s_axi_lite_bvalid,
  input  logic        s_axi_lite_bready,
  input  logic [31:0] s_axi_lite_araddr,
  input  logic        s_axi_lite_arvalid,
  output logic        s_axi_lite_arready,
  output logic [31:0] s_axi_lite_rdata,
  output logic [1:0]  s_axi_lite_rresp,
  output logic        s_axi_lite_rvalid,
  input  logic        s_axi_lite_rready,
  output logic        timer_irq,
  output logic        soft_irq
);

  localparam logic [31:0] c_addr_mask =
    32'((64'd1 << ADDR_WIDTH) - 64'd1) & 32'hFFFF_FFFC;

  wr_state_e   r_wstate;
  wr_state_e   w_wstate_next;
  rd_state_e   r_rstate;
  rd_state_e   w_rstate_next;

  logic        r_aw_held;
  logic        r_w_held;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_bresp;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_soft_irq;

  logic        w_aw_fire;
  logic        w_w_fire;
  logic        w_b_fire;
  logic        w_ar_fire;
  logic        w_r_fire;
  logic        w_commit;
  reg_sel_e    w_wsel;
  reg_sel_e    w_rsel;
  logic [31:0] w_rd_word;
  logic [63:0] w_mtime;

  assign s_axi_lite_awready = (r_wstate == W_IDLE) && !r_aw_held;
  assign s_axi_lite_wready  = (r_wstate == W_IDLE) && !r_w_held;
  assign s_axi_lite_bvalid  = (r_wstate == W_RESP);
  assign s_axi_lite_bresp   = r_bresp;
  assign s_axi_lite_arready = (r_rstate == R_IDLE);
  assign s_axi_lite_rvalid  = (r_rstate == R_DATA);
  assign s_axi_lite_rdata   = r_rdata;
  assign s_axi_lite_rresp   = r_rresp;
  assign soft_irq           = r_soft_irq;

  assign w_aw_fire = s_axi_lite_awvalid && s_axi_lite_awready;
  assign w_w_fire  = s_axi_lite_wvalid  && s_axi_lite_wready;
  assign w_b_fire  = s_axi_lite_bvalid  && s_axi_lite_bready;
  assign w_ar_fire = s_axi_lite_arvalid && s_axi_lite_arready;
  assign w_r_fire  = s_axi_lite_rvalid  && s_axi_lite_rready;
  assign w_commit  = (r_wstate == W_IDLE) && r_aw_held && r_w_held;

  assign w_wsel = decode_offset(r_awaddr & c_addr_mask);
  assign w_rsel = decode_offset(s_axi_lite_araddr & c_addr_mask);

  // ---------------- write channel ----------------
  always_ff @(posedge clk) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wstate_next;
  end

  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_commit) w_wstate_next = W_RESP;
      W_RESP:  if (w_b_fire) w_wstate_next = W_IDLE;
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= 32'd0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_aw_fire) begin
        r_awaddr  <= s_axi_lite_awaddr;
        r_aw_held <= 1'b1;
      end
      if (w_w_fire) begin
        r_wdata  <= s_axi_lite_wdata;
        r_wstrb  <= s_axi_lite_wstrb;
        r_w_held <= 1'b1;
      end
      if (w_commit) begin
        r_bresp <= (w_wsel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      end
      if (w_b_fire) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bresp   <= RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_msip     <= 1'b0;
      r_soft_irq <= 1'b0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      r_soft_irq <= r_msip;
      if (w_commit && (w_wsel == SEL_MSIP) && r_wstrb[0]) begin
        r_msip <= r_wdata[0];
      end
      if (w_commit && (w_wsel == SEL_MTIMECMP_LO)) begin
        r_mtimecmp[31:0] <= merge_strb(r_mtimecmp[31:0], r_wdata, r_wstrb);
      end
      if (w_commit && (w_wsel == SEL_MTIMECMP_HI)) begin
        r_mtimecmp[63:32] <= merge_strb(r_mtimecmp[63:32], r_wdata, r_wstrb);
      end
    end
  end

  holy_clint_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .wr_lo     (w_commit && (w_wsel == SEL_MTIME_LO)),
    .wr_hi     (w_commit && (w_wsel == SEL_MTIME_HI)),
    .wr_data   (r_wdata),
    .wr_strb   (r_wstrb),
    .mtimecmp  (r_mtimecmp),
    .mtime     (w_mtime),
    .timer_irq (timer_irq)
  );

  // ---------------- read channel ----------------
`ifdef HOLY_CLINT_MTIME_LATCH_EN
  logic [31:0] r_mtime_hi_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime_hi_shadow <= 32'd0;
    end else if (w_ar_fire && (w_rsel == SEL_MTIME_LO)) begin
      r_mtime_hi_shadow <= w_mtime[63:32];
    end
  end
`endif

  // Reads see register state from before any same-cycle write commits.
  always_comb begin
    w_rd_word = 32'd0;
    case (w_rsel)
      SEL_MSIP:        w_rd_word = {31'd0, r_msip};
      SEL_MTIMECMP_LO: w_rd_word = r_mtimecmp[31:0];
      SEL_MTIMECMP_HI: w_rd_word = r_mtimecmp[63:32];
      SEL_MTIME_LO:    w_rd_word = w_mtime[31:0];
`ifdef HOLY_CLINT_MTIME_LATCH_EN
      SEL_MTIME_HI:    w_rd_word = r_mtime_hi_shadow;
`else
      SEL_MTIME_HI:    w_rd_word = w_mtime[63:32];
`endif
      default:         w_rd_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_next;
  end

  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_fire) w_rstate_next = R_DATA;
      R_DATA:  if (w_r_fire)  w_rstate_next = R_IDLE;
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_fire) begin
      r_rdata <= w_rd_word;
      r_rresp <= (w_rsel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_holy_clint.sv
// ============================================================================
// Module      : tb_holy_clint
// Description : Randomized self-checking bench for holy_clint against a
//               cycle-indexed arithmetic model of mtime and the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_holy_clint;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axi_lite_awaddr = '0;
  logic        s_axi_lite_awvalid = 1'b0;
  logic        s_axi_lite_awready;
  logic [31:0] s_axi_lite_wdata = '0;
  logic [3:0]  s_axi_lite_wstrb = '0;
  logic        s_axi_lite_wvalid = 1'b0;
  logic        s_axi_lite_wready;
  logic [1:0]  s_axi_lite_bresp;
  logic        s_axi_lite_bvalid;
  logic        s_axi_lite_bready = 1'b0;
  logic [31:0] s_axi_lite_araddr = '0;
  logic        s_axi_lite_arvalid = 1'b0;
  logic        s_axi_lite_arready;
  logic [31:0] s_axi_lite_rdata;
  logic [1:0]  s_axi_lite_rresp;
  logic        s_axi_lite_rvalid;
  logic        s_axi_lite_rready = 1'b0;
  logic        timer_irq;
  logic        soft_irq;

  always #5 clk = ~clk;

  holy_clint #(.ADDR_WIDTH(16), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst),
    .s_axi_lite_awaddr(s_axi_lite_awaddr), .s_axi_lite_awvalid(s_axi_lite_awvalid),
    .s_axi_lite_awready(s_axi_lite_awready),
    .s_axi_lite_wdata(s_axi_lite_wdata), .s_axi_lite_wstrb(s_axi_lite_wstrb),
    .s_axi_lite_wvalid(s_axi_lite_wvalid), .s_axi_lite_wready(s_axi_lite_wready),
    .s_axi_lite_bresp(s_axi_lite_bresp), .s_axi_lite_bvalid(s_axi_lite_bvalid),
    .s_axi_lite_bready(s_axi_lite_bready),
    .s_axi_lite_araddr(s_axi_lite_araddr), .s_axi_lite_arvalid(s_axi_lite_arvalid),
    .s_axi_lite_arready(s_axi_lite_arready),
    .s_axi_lite_rdata(s_axi_lite_rdata), .s_axi_lite_rresp(s_axi_lite_rresp),
    .s_axi_lite_rvalid(s_axi_lite_rvalid), .s_axi_lite_rready(s_axi_lite_rready),
    .timer_irq(timer_irq), .soft_irq(soft_irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Number of clock edges since reset was released.
  longint unsigned edge_cnt;
  always @(posedge clk) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  // Reference model: mtime is an affine function of the edge count.
  logic [63:0]     m_base_val;
  longint unsigned m_base_k;
  logic [63:0]     m_cmp;
  logic            m_msip;
  logic [31:0]     m_shadow;

  function automatic logic [63:0] mtime_at(input longint unsigned k);
    return m_base_val + 64'(k / P) - 64'(m_base_k / P);
  endfunction

  function automatic int sel_of(input logic [31:0] addr);
    logic [15:0] off;
    off = addr[15:0] & 16'hFFFC;
    case (off)
      16'h0000: return 0;
      16'h4000: return 1;
      16'h4004: return 2;
      16'hBFF8: return 3;
      16'hBFFC: return 4;
      default:  return 5;
    endcase
  endfunction

  function automatic logic [31:0] bytes_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input longint unsigned k);
    logic [63:0] t;
    t = mtime_at(k);
    case (sel_of(addr))
      0: return {31'd0, m_msip};
      1: return m_cmp[31:0];
      2: return m_cmp[63:32];
      3: begin
`ifdef HOLY_CLINT_MTIME_LATCH_EN
        m_shadow = t[63:32];
`endif
        return t[31:0];
      end
`ifdef HOLY_CLINT_MTIME_LATCH_EN
      4: return m_shadow;
`else
      4: return t[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb, input longint unsigned ck);
    logic [63:0] pre;
    pre = mtime_at(ck - 1);
    case (sel_of(addr))
      0: if (strb[0]) m_msip = data[0];
      1: m_cmp[31:0]  = bytes_merge(m_cmp[31:0], data, strb);
      2: m_cmp[63:32] = bytes_merge(m_cmp[63:32], data, strb);
      3: begin pre[31:0]  = bytes_merge(pre[31:0], data, strb);  m_base_val = pre; m_base_k = ck; end
      4: begin pre[63:32] = bytes_merge(pre[63:32], data, strb); m_base_val = pre; m_base_k = ck; end
      default: ;
    endcase
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    s_axi_lite_awvalid = 0; s_axi_lite_wvalid = 0; s_axi_lite_bready = 0;
    s_axi_lite_arvalid = 0; s_axi_lite_rready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_base_val = 0; m_base_k = 0; m_cmp = '1; m_msip = 0; m_shadow = 0;
  endtask

  // Bus driver: AW leads W by `lead` cycles, bready is withheld `bdelay` cycles.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int bdelay, output logic [1:0] resp,
                           output logic soft_first, output logic soft_next);
    longint unsigned ck;
    @(negedge clk);
    s_axi_lite_awaddr = addr; s_axi_lite_awvalid = 1;
    if (lead == 0) begin
      s_axi_lite_wdata = data; s_axi_lite_wstrb = strb; s_axi_lite_wvalid = 1;
    end
    for (int i = 0; i < lead; i++) begin
      @(negedge clk);
      s_axi_lite_awvalid = 0;
      n_checks++;
      if (s_axi_lite_awready !== 1'b0) $display("FAIL aw_dropped: awready=%b want 0", s_axi_lite_awready);
      else n_pass++;
    end
    if (lead > 0) begin
      s_axi_lite_wdata = data; s_axi_lite_wstrb = strb; s_axi_lite_wvalid = 1;
    end
    @(negedge clk);
    s_axi_lite_awvalid = 0; s_axi_lite_wvalid = 0;
    s_axi_lite_bready = (bdelay == 0);
    n_checks++;
    if (s_axi_lite_wready !== 1'b0 || s_axi_lite_bvalid !== 1'b0)
      $display("FAIL w_captured: wready=%b bvalid=%b want 0 0", s_axi_lite_wready, s_axi_lite_bvalid);
    else n_pass++;
    @(negedge clk);
    ck = edge_cnt;
    resp = s_axi_lite_bresp; soft_first = soft_irq; soft_next = soft_irq;
    n_checks++;
    if (s_axi_lite_bvalid !== 1'b1) $display("FAIL b_latency: bvalid=%b want 1", s_axi_lite_bvalid);
    else n_pass++;
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk);
      if (i == 0) soft_next = soft_irq;
      n_checks++;
      if (s_axi_lite_bvalid !== 1'b1 || s_axi_lite_bresp !== resp)
        $display("FAIL b_hold: bvalid=%b bresp=%b want 1 %b", s_axi_lite_bvalid, s_axi_lite_bresp, resp);
      else n_pass++;
    end
    s_axi_lite_bready = 1;
    @(negedge clk);
    if (bdelay == 0) soft_next = soft_irq;
    s_axi_lite_bready = 0;
    n_checks++;
    if (s_axi_lite_bvalid !== 1'b0 || s_axi_lite_awready !== 1'b1 || s_axi_lite_wready !== 1'b1)
      $display("FAIL b_release: bvalid=%b awready=%b wready=%b want 0 1 1",
               s_axi_lite_bvalid, s_axi_lite_awready, s_axi_lite_wready);
    else n_pass++;
    model_write(addr, data, strb, ck);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rdelay, output logic [31:0] data,
                          output logic [1:0] resp, output longint unsigned k0);
    @(negedge clk);
    s_axi_lite_araddr = addr; s_axi_lite_arvalid = 1;
    k0 = edge_cnt;
    @(negedge clk);
    s_axi_lite_arvalid = 0;
    data = s_axi_lite_rdata; resp = s_axi_lite_rresp;
    n_checks++;
    if (s_axi_lite_rvalid !== 1'b1 || s_axi_lite_arready !== 1'b0)
      $display("FAIL r_latency: rvalid=%b arready=%b want 1 0", s_axi_lite_rvalid, s_axi_lite_arready);
    else n_pass++;
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clk);
      n_checks++;
      if (s_axi_lite_rvalid !== 1'b1 || s_axi_lite_rdata !== data)
        $display("FAIL r_hold: rvalid=%b rdata=%h want 1 %h", s_axi_lite_rvalid, s_axi_lite_rdata, data);
      else n_pass++;
    end
    s_axi_lite_rready = 1;
    @(negedge clk);
    s_axi_lite_rready = 0;
    n_checks++;
    if (s_axi_lite_rvalid !== 1'b0 || s_axi_lite_arready !== 1'b1)
      $display("FAIL r_release: rvalid=%b arready=%b want 0 1", s_axi_lite_rvalid, s_axi_lite_arready);
    else n_pass++;
  endtask

  logic [31:0]     rd, exp;
  logic [1:0]      rs, bs;
  logic            sf, sn;
  longint unsigned k0;

  task automatic test_reset();
    reset_dut();
    n_checks++;
    if ({s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_arready, s_axi_lite_bvalid, s_axi_lite_rvalid,
         s_axi_lite_bresp, s_axi_lite_rresp, timer_irq, soft_irq} !== 11'b111_00_00_00_00 ||
        s_axi_lite_rdata !== 32'd0)
      $display("FAIL reset_outputs: aw/w/ar=%b%b%b bv/rv=%b%b resp=%b/%b irq=%b%b rdata=%h",
               s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_arready, s_axi_lite_bvalid,
               s_axi_lite_rvalid, s_axi_lite_bresp, s_axi_lite_rresp, timer_irq, soft_irq, s_axi_lite_rdata);
    else n_pass++;
    axi_read(32'h4000, 0, rd, rs, k0);
    n_checks++;
    if (rd !== 32'hFFFF_FFFF || rs !== 2'b00) $display("FAIL reset_cmp_lo: got %h/%b want ffffffff/00", rd, rs);
    else n_pass++;
    axi_read(32'h4004, 1, rd, rs, k0);
    n_checks++;
    if (rd !== 32'hFFFF_FFFF || rs !== 2'b00) $display("FAIL reset_cmp_hi: got %h/%b want ffffffff/00", rd, rs);
    else n_pass++;
    axi_read(32'hBFF8, 0, rd, rs, k0);
    exp = model_read(32'hBFF8, k0);
    n_checks++;
    if (rd !== exp) $display("FAIL reset_mtime_lo: got %h want %h", rd, exp);
    else n_pass++;
  endtask

  task automatic test_msip();
    axi_write(32'h0000, 32'h1, 4'hF, 0, 0, bs, sf, sn);
    n_checks++;
    if (bs !== 2'b00 || sf !== 1'b0 || sn !== 1'b1)
      $display("FAIL msip_set: bresp=%b soft=%b->%b want 00 0->1", bs, sf, sn);
    else n_pass++;
    axi_write(32'h0000, 32'h0, 4'hF, 1, 2, bs, sf, sn);
    n_checks++;
    if (bs !== 2'b00 || sf !== 1'b1 || sn !== 1'b0)
      $display("FAIL msip_clear: bresp=%b soft=%b->%b want 00 1->0", bs, sf, sn);
    else n_pass++;
  endtask

  task automatic test_timer();
    longint unsigned rise_k;
    reset_dut();
    axi_write(32'h4004, 32'h0, 4'hF, 0, 0, bs, sf, sn);
    axi_write(32'h4000, 32'd10, 4'hF, 0, 0, bs, sf, sn);
    rise_k = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      n_checks++;
      if (timer_irq !== (mtime_at(edge_cnt - 1) >= m_cmp))
        $display("FAIL timer_irq_level: edge %0d got %b want %b", edge_cnt, timer_irq, !timer_irq);
      else n_pass++;
      if (timer_irq === 1'b1 && rise_k == 0) rise_k = edge_cnt;
    end
    n_checks++;
    if (rise_k != longint'(10 * P + 1)) $display("FAIL timer_irq_rise: edge %0d want %0d", rise_k, 10 * P + 1);
    else n_pass++;
    axi_write(32'h4000, 32'hFFFF_FFFF, 4'hF, 0, 0, bs, sf, sn);
    n_checks++;
    if (timer_irq !== 1'b0) $display("FAIL timer_irq_fall: got %b want 0", timer_irq);
    else n_pass++;
  endtask

  task automatic test_strobe();
    axi_write(32'h4000, 32'h0000_AB00, 4'b0010, 3, 5, bs, sf, sn);
    axi_read(32'h4000, 0, rd, rs, k0);
    n_checks++;
    if (rd !== 32'hFFFF_ABFF || rd !== model_read(32'h4000, k0))
      $display("FAIL strobe_byte1: got %h want ffffabff", rd);
    else n_pass++;
  endtask

  task automatic test_unmapped();
    axi_write(32'h1234, 32'hDEAD_BEEF, 4'hF, 0, 1, bs, sf, sn);
    n_checks++;
    if (bs !== 2'b10) $display("FAIL unmapped_bresp: got %b want 10", bs);
    else n_pass++;
    axi_read(32'h1234, 0, rd, rs, k0);
    n_checks++;
    if (rd !== 32'd0 || rs !== 2'b10) $display("FAIL unmapped_read: got %h/%b want 0/10", rd, rs);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = (i == 0) ? 32'h0 : (i == 1) ? 32'h4000 : 32'h4004;
      axi_read(a, 0, rd, rs, k0);
      exp = model_read(a, k0);
      n_checks++;
      if (rd !== exp || rs !== 2'b00) $display("FAIL unmapped_intact %h: got %h want %h", a, rd, exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pre, nw;
    pre = m_cmp[63:32];
    nw  = $urandom();
    fork
      axi_write(32'h4004, nw, 4'hF, 0, 0, bs, sf, sn);
      axi_read(32'h4004, 0, rd, rs, k0);
    join
    n_checks++;
    if (rd !== pre) $display("FAIL rw_same_cycle: got %h want %h", rd, pre);
    else n_pass++;
    axi_read(32'h4004, 0, rd, rs, k0);
    n_checks++;
    if (rd !== nw) $display("FAIL rw_after: got %h want %h", rd, nw);
    else n_pass++;
  endtask

  task automatic test_carry();
    logic [31:0] hi_expected;
    axi_write(32'hBFFC, 32'h0, 4'hF, 0, 0, bs, sf, sn);
    axi_write(32'hBFF8, 32'hFFFF_FFFE, 4'hF, 0, 0, bs, sf, sn);
    axi_read(32'hBFF8, 0, rd, rs, k0);
    exp = model_read(32'hBFF8, k0);
    n_checks++;
    if (rd !== exp) $display("FAIL carry_lo: got %h want %h", rd, exp);
    else n_pass++;
    repeat (12) @(negedge clk);
    axi_read(32'hBFFC, 0, rd, rs, k0);
    exp = model_read(32'hBFFC, k0);
`ifdef HOLY_CLINT_MTIME_LATCH_EN
    hi_expected = 32'd0;
`else
    hi_expected = 32'd1;
`endif
    n_checks++;
    if (rd !== exp || rd !== hi_expected) $display("FAIL carry_hi: got %h want %h", rd, hi_expected);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    s_axi_lite_awaddr = 32'h4000; s_axi_lite_wdata = 32'h0; s_axi_lite_wstrb = 4'hF;
    s_axi_lite_awvalid = 1; s_axi_lite_wvalid = 1;
    @(negedge clk);
    s_axi_lite_awvalid = 0; s_axi_lite_wvalid = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_base_val = 0; m_base_k = 0; m_cmp = '1; m_msip = 0; m_shadow = 0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (s_axi_lite_bvalid !== 1'b0 || s_axi_lite_awready !== 1'b1)
        $display("FAIL reset_abort: bvalid=%b awready=%b want 0 1", s_axi_lite_bvalid, s_axi_lite_awready);
      else n_pass++;
    end
    axi_read(32'h4000, 0, rd, rs, k0);
    n_checks++;
    if (rd !== 32'hFFFF_FFFF) $display("FAIL reset_abort_cmp: got %h want ffffffff", rd);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] offs [6];
    offs = '{32'h0, 32'h4000, 32'h4004, 32'hBFF8, 32'hBFFC, 32'h1234};
    for (int n = 0; n < 40; n++) begin
      logic [31:0] rnd, addr, data;
      int pick;
      rnd  = $urandom();
      pick = $urandom_range(0, 5);
      addr = {rnd[31:16], offs[pick][15:2], rnd[1:0]};
      data = $urandom();
      if ($urandom_range(0, 1) == 0) begin
        axi_write(addr, data, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                  bs, sf, sn);
        n_checks++;
        if (bs !== ((pick == 5) ? 2'b10 : 2'b00)) $display("FAIL rnd_bresp %h: got %b", addr, bs);
        else n_pass++;
      end else begin
        axi_read(addr, $urandom_range(0, 3), rd, rs, k0);
        exp = model_read(addr, k0);
        n_checks++;
        if (rd !== exp || rs !== ((pick == 5) ? 2'b10 : 2'b00))
          $display("FAIL rnd_read %h: got %h/%b want %h", addr, rd, rs, exp);
        else n_pass++;
      end
      n_checks++;
      if (soft_irq !== m_msip || timer_irq !== (mtime_at(edge_cnt - 1) >= m_cmp))
        $display("FAIL rnd_irqs: soft=%b timer=%b want %b %b", soft_irq, timer_irq, m_msip,
                 mtime_at(edge_cnt - 1) >= m_cmp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_msip();
    test_timer();
    test_strobe();
    test_unmapped();
    test_back_to_back();
    test_carry();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/holy_clint.md
Name: holy_clint

Overview:
- AXI-Lite slave core-local interruptor for the Holy Core SoC.
- Sits downstream of the core's AXI-Lite master port (m_axi_lite_*) and consumes its register accesses.
- Feeds the core's timer_irq and soft_irq inputs, directly upstream of them.
- Implements the RISC-V machine timer (mtime/mtimecmp) and the software-interrupt register (msip).

Parameters:
- ADDR_WIDTH, 16, number of low address bits decoded; upper bits are ignored (the interconnect has already decoded the base).
- PRESCALE, 1, clk cycles per mtime increment; legal range 1..65535.

Ports:
- clk  in  1  single system clock; all logic rises on it.
- rst  in  1  synchronous, active-high reset.
- s_axi_lite_awaddr  in  32  write address.
- s_axi_lite_awvalid  in  1  write address valid.
- s_axi_lite_awready  out  1  write address ready.
- s_axi_lite_wdata  in  32  write data.
- s_axi_lite_wstrb  in  4  byte enables.
- s_axi_lite_wvalid  in  1  write data valid.
- s_axi_lite_wready  out  1  write data ready.
- s_axi_lite_bresp  out  2  write response.
- s_axi_lite_bvalid  out  1  write response valid.
- s_axi_lite_bready  in  1  write response ready.
- s_axi_lite_araddr  in  32  read address.
- s_axi_lite_arvalid  in  1  read address valid.
- s_axi_lite_arready  out  1  read address ready.
- s_axi_lite_rdata  out  32  read data.
- s_axi_lite_rresp  out  2  read response.
- s_axi_lite_rvalid  out  1  read data valid.
- s_axi_lite_rready  in  1  read data ready.
- timer_irq  out  1  registered (mtime >= mtimecmp).
- soft_irq  out  1  msip[0].

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; msip = 0.
  - timer_irq = 0; soft_irq = 0.
  - awready = 1, wready = 1, arready = 1.
  - bvalid = 0, rvalid = 0, bresp = 0, rresp = 0, rdata = 0.
- Register map (byte offsets; address bits [1:0] are ignored):
  - 0x0000 msip: only bit 0 is writable, other bits read 0.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
- Write FSM (W_IDLE, W_RESP):
  - AW and W are captured independently; each ready drops once its channel is captured.
  - When both are held, the register update happens that cycle with per-byte wstrb, and the FSM enters W_RESP with bvalid = 1 on the next cycle.
  - bvalid and bresp hold until bready. On the bvalid && bready cycle: return to W_IDLE, and awready/wready reassert the following cycle.
  - Unmapped offset: no state change, bresp = 2'b10 (SLVERR); otherwise OKAY.
- Read FSM (R_IDLE, R_DATA):
  - arready = 1 in R_IDLE; an arvalid && arready handshake captures the address.
  - rdata and rvalid are registered and appear the next cycle (1-cycle latency).
  - They hold until rready, then return to R_IDLE, and arready reasserts the following cycle.
  - Unmapped offset: rdata = 0, rresp = SLVERR.
- mtime counting:
  - A prescale counter counts 0..PRESCALE-1; mtime increments when it wraps.
  - PRESCALE = 1 means mtime increments every cycle.
  - mtime wraps from all-ones to 0 with no flag.
- Write vs increment: a bus write to an mtime half takes priority over the increment in the same cycle. The written half takes the strobed data; the other half keeps its pre-increment value, with no carry.
- Simultaneous read and write: allowed. A read in the same cycle as a write to the same register returns the pre-write value.
- timer_irq:
  - Recomputed every cycle from the post-update mtime/mtimecmp, registered; it lags by 1 cycle.
  - Level-sensitive; cleared only by raising mtimecmp or rewriting mtime.
- soft_irq: equals msip[0], registered; it changes the cycle after the write.
- Reset mid-transaction: outstanding handshakes are dropped, all outputs return to reset values, and no response is issued for the aborted access.

Optional Feature:
- Macro HOLY_CLINT_MTIME_LATCH_EN.
- Defined:
  - A read of 0xBFF8 snapshots mtime[63:32] into a shadow register.
  - A read of 0xBFFC returns the shadow, giving coherent 64-bit reads across a low-word carry.
  - The shadow resets to 0.
- Undefined: 0xBFFC returns live mtime[63:32], and no shadow register exists.

Decomposition:
- Shared package holy_clint_pkg holds:
  - offset constants CLINT_MSIP_OFF, CLINT_MTIMECMP_LO_OFF, CLINT_MTIMECMP_HI_OFF, CLINT_MTIME_LO_OFF, CLINT_MTIME_HI_OFF;
  - AXI resp constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - FSM state typedefs.
- One natural sub-module, holy_clint_timer: the prescaler, 64-bit mtime with strobed write override, and the comparator. The AXI-Lite slave FSMs stay in the top.

Test Plan:
- Reset, then read 0x4000 and 0x4004 → both 0xFFFFFFFF, rresp OKAY; timer_irq = 0; soft_irq = 0.
- Write 0x0000 = 0x1, bready held 1 → bvalid one cycle after both channels are captured; soft_irq = 1 the following cycle. Write 0 → soft_irq = 0.
- PRESCALE = 4: write mtimecmp lo = 10 and hi = 0 → timer_irq rises exactly 1 cycle after mtime reaches 10 (about 40 cycles after the mtime reset). Write mtimecmp lo = 0xFFFFFFFF → timer_irq falls.
- AW presented 3 cycles before W, with wstrb = 4'b0010 and data 0x0000AB00 to 0x4000 → only byte 1 changes, to 0xAB. bvalid held 5 cycles while bready = 0.
- Read and write to 0x1234 → rdata = 0, rresp = 2'b10, bresp = 2'b10; no register changes.
- Write mtime lo = 0xFFFFFFFE, hi = 0, then read lo then hi → with HOLY_CLINT_MTIME_LATCH_EN, hi matches the value at the lo read; without it, hi = 1 once the carry has occurred.
